instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv32i_pkg.sv | 22 ++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I definitions for the fetch path: default XLEN,
//                the canonical NOP encoding (addi x0,x0,0) and the
//                instruction-fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Single-outstanding instruction fetch unit. Accepts a PC,
//                issues one request to instruction memory, waits for the
//                response and presents the word to the decoder until it is
//                consumed. A redirect (flush) kills the fetch in flight.
//  Ports       : clk, rst (async, active-high)
//                pc_addr/pc_valid          - fetch request from the PC
//                flush                     - redirect pulse
//                imem_req/imem_addr        - request to instruction memory
//                imem_gnt/imem_rvalid/imem_rdata - memory handshake/response
//                instr/instr_pc/instr_valid/instr_ready - decoder handshake
//                fetch_busy                - PC must hold while high
//                misalign_err              - misaligned fetch flag
//  Config      : IFETCH_MISALIGN_CHECK_EN - when defined, a misaligned PC
//                bypasses memory and yields a flagged NOP. When undefined,
//                the low two address bits are forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_busy,
    output logic              misalign_err
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    // Set by a flush while a request is in flight; the next response is
    // then thrown away instead of being presented.
    logic              r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_drop       <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            fetch_busy   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A redirect in the same cycle means pc_addr is stale.
                    if (pc_valid && !flush) begin
                        r_addr     <= pc_addr;
                        fetch_busy <= 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
                        if (pc_addr[1:0] != 2'b00) begin
                            r_state      <= ST_HOLD;
                            instr        <= DATA_W'(NOP_INSTR);
                            instr_pc     <= pc_addr;
                            instr_valid  <= 1'b1;
                            misalign_err <= 1'b1;
                        end else begin
                            r_state   <= ST_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_addr;
                        end
`else
                        r_state   <= ST_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= {pc_addr[ADDR_W-1:2], 2'b00};
`endif
                    end
                end

                ST_REQ: begin
                    // The request stays up until granted even on flush; the
                    // flush only marks the eventual response for discard.
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_drop <= 1'b0;
                        if (r_drop || flush) begin
                            r_state    <= ST_IDLE;
                            fetch_busy <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= r_addr;
                            instr_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Flush wins over ready: the word is treated as unused.
                    if (flush || instr_ready) begin
                        instr_valid  <= 1'b0;
                        misalign_err <= 1'b0;
                        fetch_busy   <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A table of fetch
//                transactions (grant/response/ready delays, optional flush
//                in WAIT) plus directed sequences for reset, flush and
//                misalignment corner cases.
//  Config      : IFETCH_MISALIGN_CHECK_EN selects the misalign expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_busy;
    logic              misalign_err;

    int n_checks;
    int n_errors;

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr      (pc_addr),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .fetch_busy   (fetch_busy),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          gnt_wait;
        int          rv_wait;
        int          ready_wait;
        bit          flush_wait;
        bit          exp_valid;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The memory model must never grant and respond in the same cycle.
    always @(posedge clk) begin
        if (imem_gnt && imem_rvalid) begin
            n_errors++;
            $display("FAIL protocol: imem_gnt and imem_rvalid together at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Issue a fetch and take it through the grant; returns with the DUT in WAIT.
    task automatic start_fetch(input logic [31:0] addr);
        @(negedge clk);
        pc_valid = 1'b1;
        pc_addr  = addr;
        @(negedge clk);
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input bit with_flush);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        flush       = with_flush;
        @(negedge clk);
        imem_rvalid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] held;
        @(negedge clk);
        pc_valid = 1'b1;
        pc_addr  = v.addr;
        @(negedge clk);
        pc_valid = 1'b0;
        check($sformatf("v%0d req", idx), {63'd0, imem_req}, 64'd1);
        check($sformatf("v%0d addr", idx), {32'd0, imem_addr}, {32'd0, v.addr & 32'hFFFF_FFFC});
        check($sformatf("v%0d busy", idx), {63'd0, fetch_busy}, 64'd1);
        for (int i = 0; i < v.gnt_wait; i++) begin
            @(negedge clk);
            check($sformatf("v%0d stall req", idx), {63'd0, imem_req}, 64'd1);
            check($sformatf("v%0d stall addr", idx), {32'd0, imem_addr}, {32'd0, v.addr & 32'hFFFF_FFFC});
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check($sformatf("v%0d req drop", idx), {63'd0, imem_req}, 64'd0);
        for (int i = 0; i < v.rv_wait; i++) begin
            flush = v.flush_wait && (i == v.rv_wait - 1);
            @(negedge clk);
            flush = 1'b0;
            check($sformatf("v%0d wait valid", idx), {63'd0, instr_valid}, 64'd0);
        end
        respond(v.data, 1'b0);
        check($sformatf("v%0d valid", idx), {63'd0, instr_valid}, {63'd0, v.exp_valid});
        if (v.exp_valid) begin
            check($sformatf("v%0d instr", idx), {32'd0, instr}, {32'd0, v.data});
            check($sformatf("v%0d pc", idx), {32'd0, instr_pc}, {32'd0, v.addr});
            held = instr;
            for (int i = 0; i < v.ready_wait; i++) begin
                @(negedge clk);
                check($sformatf("v%0d bp instr", idx), {32'd0, instr}, {32'd0, held});
                check($sformatf("v%0d bp pc", idx), {32'd0, instr_pc}, {32'd0, v.addr});
                check($sformatf("v%0d bp busy", idx), {63'd0, fetch_busy}, 64'd1);
            end
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            check($sformatf("v%0d consumed", idx), {63'd0, instr_valid}, 64'd0);
        end
        check($sformatf("v%0d idle", idx), {63'd0, fetch_busy}, 64'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        pc_addr     = '0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;

        //            addr          data          gnt rv rdy flush valid
        vecs[0] = '{32'h0000_0000, 32'h0000_0093, 0, 0, 0, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0004, 32'h0010_0113, 0, 0, 0, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0008, 32'h0020_8193, 0, 0, 0, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0100, 32'h1234_5678, 5, 0, 0, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_0020, 32'hDEAD_BEEF, 0, 1, 0, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0040, 32'hCAFE_F00D, 0, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_0080, 32'h0BAD_C0DE, 1, 2, 4, 1'b0, 1'b1};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset req", {63'd0, imem_req}, 64'd0);
        check("reset addr", {32'd0, imem_addr}, 64'd0);
        check("reset valid", {63'd0, instr_valid}, 64'd0);
        check("reset instr", {32'd0, instr}, 64'd0);
        check("reset busy", {63'd0, fetch_busy}, 64'd0);
        check("reset misalign", {63'd0, misalign_err}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush in IDLE blocks the pc_valid of that cycle.
        @(negedge clk);
        pc_valid = 1'b1;
        pc_addr  = 32'h0000_0300;
        flush    = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        flush    = 1'b0;
        check("idle flush req", {63'd0, imem_req}, 64'd0);
        check("idle flush busy", {63'd0, fetch_busy}, 64'd0);

        // Flush in REQ: request held until grant, response discarded.
        @(negedge clk);
        pc_valid = 1'b1;
        pc_addr  = 32'h0000_0200;
        @(negedge clk);
        pc_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        check("req flush req held", {63'd0, imem_req}, 64'd1);
        check("req flush addr held", {32'd0, imem_addr}, 64'h200);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        respond(32'h1111_1111, 1'b0);
        check("req flush valid", {63'd0, instr_valid}, 64'd0);
        check("req flush busy", {63'd0, fetch_busy}, 64'd0);

        // Flush together with rvalid discards the data.
        start_fetch(32'h0000_0210);
        respond(32'h2222_2222, 1'b1);
        check("rv flush valid", {63'd0, instr_valid}, 64'd0);
        check("rv flush busy", {63'd0, fetch_busy}, 64'd0);

        // Flush together with ready in HOLD: back to IDLE, word dropped.
        start_fetch(32'h0000_0220);
        respond(32'h3333_3333, 1'b0);
        check("hold valid", {63'd0, instr_valid}, 64'd1);
        flush       = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        flush       = 1'b0;
        instr_ready = 1'b0;
        check("hold flush valid", {63'd0, instr_valid}, 64'd0);
        check("hold flush busy", {63'd0, fetch_busy}, 64'd0);

        // Asynchronous reset between edges while in WAIT.
        start_fetch(32'h0000_0230);
        check("pre-reset busy", {63'd0, fetch_busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async busy", {63'd0, fetch_busy}, 64'd0);
        check("async addr", {32'd0, imem_addr}, 64'd0);
        check("async req", {63'd0, imem_req}, 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        respond(32'h4444_4444, 1'b0);
        check("late rvalid valid", {63'd0, instr_valid}, 64'd0);
        check("late rvalid instr", {32'd0, instr}, 64'd0);
        check("late rvalid busy", {63'd0, fetch_busy}, 64'd0);

        // Misaligned PC.
        @(negedge clk);
        pc_valid = 1'b1;
        pc_addr  = 32'h0000_0102;
        @(negedge clk);
        pc_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("mis req", {63'd0, imem_req}, 64'd0);
        check("mis valid", {63'd0, instr_valid}, 64'd1);
        check("mis instr", {32'd0, instr}, 64'h13);
        check("mis pc", {32'd0, instr_pc}, 64'h102);
        check("mis flag", {63'd0, misalign_err}, 64'd1);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("mis clr valid", {63'd0, instr_valid}, 64'd0);
        check("mis clr flag", {63'd0, misalign_err}, 64'd0);
`else
        check("mis req", {63'd0, imem_req}, 64'd1);
        check("mis addr", {32'd0, imem_addr}, 64'h100);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        respond(32'h5555_5555, 1'b0);
        check("mis instr", {32'd0, instr}, 64'h5555_5555);
        check("mis flag", {63'd0, misalign_err}, 64'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("mis clr valid", {63'd0, instr_valid}, 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
